// File: rtl/pipelined_adder_subtractor_if.sv
// Operand/result bundle for the pipelined adder/subtractor.
// The master drives operands and the clock enable. The slave returns the registered result and flags.
interface pipelined_adder_subtractor_if #(
    parameter int N = 8
);
    logic         ce;
    logic         in_valid;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         op;
    logic         sat;
    logic         out_valid;
    logic [N-1:0] Result;
    logic         CarryOut;
    logic         Overflow;

    modport master (
        output ce, in_valid, A, B, op, sat,
        input  out_valid, Result, CarryOut, Overflow
    );

    modport slave (
        input  ce, in_valid, A, B, op, sat,
        output out_valid, Result, CarryOut, Overflow
    );
endinterface

// File: rtl/pipelined_adder_subtractor.sv
// N-bit two's-complement adder/subtractor whose carry chain is cut into SEGS registered segments.
// The final stage applies the overflow flag and optional signed saturation.
module pipelined_adder_subtractor #(
    parameter int N    = 8,
    parameter int SEGS = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    pipelined_adder_subtractor_if.slave   bus
);

    localparam int W = (SEGS > 0) ? N / SEGS : 1;
    localparam int L = SEGS - 1;

    if (N < 2 || SEGS < 1 || SEGS > N || (N % SEGS) != 0) begin : gBadParams
        $error("pipelined_adder_subtractor: illegal N/SEGS combination");
    end

    logic [N-1:0] w_aIn      [SEGS];
    logic [N-1:0] w_bIn      [SEGS];
    logic [N-1:0] w_sumIn    [SEGS];
    logic         w_cIn      [SEGS];
    logic         w_satIn    [SEGS];
    logic         w_validIn  [SEGS];
    logic [W:0]   w_seg      [SEGS];
    logic [N-1:0] w_sumOut   [SEGS];
    logic [N-1:0] w_stageOut [SEGS];
    logic         w_ovf;
    logic [N-1:0] w_result;

    logic [N-1:0] r_a     [SEGS];
    logic [N-1:0] r_b     [SEGS];
    logic [N-1:0] r_sum   [SEGS];
    logic         r_carry [SEGS];
    logic         r_sat   [SEGS];
    logic         r_valid [SEGS];
    logic         r_ovf;

    for (genvar k = 0; k < SEGS; k++) begin : gStage
        localparam logic [N-1:0] SEG_MASK = N'({W{1'b1}}) << (k * W);

        // Stage 0 pre-inverts B so later stages only ever add; op becomes the first carry-in
        if (k == 0) begin : gFirst
            assign w_aIn[k]     = bus.A;
            assign w_bIn[k]     = bus.op ? ~bus.B : bus.B;
            assign w_sumIn[k]   = '0;
            assign w_cIn[k]     = bus.op;
            assign w_satIn[k]   = bus.sat;
            assign w_validIn[k] = bus.in_valid;
        end else begin : gNext
            assign w_aIn[k]     = r_a[k-1];
            assign w_bIn[k]     = r_b[k-1];
            assign w_sumIn[k]   = r_sum[k-1];
            assign w_cIn[k]     = r_carry[k-1];
            assign w_satIn[k]   = r_sat[k-1];
            assign w_validIn[k] = r_valid[k-1];
        end

        assign w_seg[k] = (W+1)'(w_aIn[k][k*W +: W])
                        + (W+1)'(w_bIn[k][k*W +: W])
                        + (W+1)'(w_cIn[k]);

        assign w_sumOut[k] = (w_sumIn[k] & ~SEG_MASK) | (N'(w_seg[k][W-1:0]) << (k * W));

        if (k == L) begin : gLast
            assign w_stageOut[k] = w_result;
        end else begin : gMid
            assign w_stageOut[k] = w_sumOut[k];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_a[k]     <= '0;
                r_b[k]     <= '0;
                r_sum[k]   <= '0;
                r_carry[k] <= 1'b0;
                r_sat[k]   <= 1'b0;
                r_valid[k] <= 1'b0;
            end else if (bus.ce) begin
                r_a[k]     <= w_aIn[k];
                r_b[k]     <= w_bIn[k];
                r_sum[k]   <= w_stageOut[k];
                r_carry[k] <= w_seg[k][W];
                r_sat[k]   <= w_satIn[k];
                r_valid[k] <= w_validIn[k];
            end
        end
    end

    // Overflow is judged on the unsaturated sum; saturation only replaces the data word
    assign w_ovf    = (w_aIn[L][N-1] == w_bIn[L][N-1]) && (w_sumOut[L][N-1] != w_aIn[L][N-1]);
    assign w_result = (w_satIn[L] && w_ovf)
                    ? (w_aIn[L][N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}})
                    : w_sumOut[L];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (bus.ce) begin
            r_ovf <= w_ovf;
        end
    end

    assign bus.out_valid = r_valid[L];
    assign bus.Result    = r_sum[L];
    assign bus.CarryOut  = r_carry[L];
    assign bus.Overflow  = r_ovf;

endmodule

// File: doc/pipelined_adder_subtractor.md
Name: pipelined_adder_subtractor

Overview:
Parametrised, pipelined N-bit two's-complement adder/subtractor. The carry chain is split into SEGS equal segments, with one segment resolved per cycle, so that retiming experiments can trade latency against cycle time. Throughput is one operation per cycle. The block adds a valid pipeline, clock-enable stall and optional signed saturation. It replaces the combinational adder/subtractor on datapaths that need registered timing.

Parameters:
N, 8, operand/result width in bits; N >= 2.
SEGS, 2, number of carry segments = pipeline depth; 1 <= SEGS <= N; N % SEGS == 0 (elaboration error otherwise).

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
ce  input  1  clock enable; 0 freezes every pipeline register
in_valid  input  1  A/B/op/sat carry a valid operation this cycle
A  input  N  operand A
B  input  N  operand B
op  input  1  0 = A+B, 1 = A-B
sat  input  1  1 = saturate Result on signed overflow
out_valid  output  1  Result/CarryOut/Overflow valid
Result  output  N  sum/difference, saturated when requested
CarryOut  output  1  carry out of MSB (subtract: 1 = no borrow, A >= B unsigned)
Overflow  output  1  signed overflow of the unsaturated result

Behaviour:
- Reset: while rst=1, all pipeline registers and outputs clear asynchronously: out_valid=0, Result=0, CarryOut=0, Overflow=0. A reset mid-operation discards every in-flight operation; none appear after reset is released.
- Arithmetic:
  - Subtraction is computed as A + ~B + 1; the segment-0 carry-in = op.
  - CarryOut = carry out of bit N-1 of that sum.
  - Overflow = (A[N-1] == B'[N-1]) && (raw[N-1] != A[N-1]), with B' = op ? ~B : B.
  - Saturation: if sat=1 and Overflow=1, Result = A[N-1] ? {1'b1, (N-1){0}} : {1'b0, (N-1){1}}. Otherwise Result = raw.
  - CarryOut and Overflow are never altered by saturation.
- Pipeline:
  - Segment width W = N/SEGS.
  - Stage k (k = 0..SEGS-1) computes bits [k*W +: W] from the registered carry of stage k-1.
  - Already-computed low result bits, the not-yet-used operand bits, op, sat and valid travel alongside in registers.
  - Saturation and flag logic are applied in the final stage, which registers the outputs.
- Latency: a transaction sampled at edge t (ce=1) appears at the outputs after edge t+SEGS-1 of enabled cycles. Its outputs are therefore visible after exactly SEGS ce-enabled edges.
- Stall: when ce=0, all registers (including out_valid and the outputs) hold their values, and inputs are ignored that cycle. No transaction is lost or duplicated across any stall length.
- Bubbles: when in_valid=0 at a sampling edge, a bubble enters the pipeline. The bubble produces out_valid=0 SEGS enabled cycles later; data registers may update but are don't-care while out_valid=0.
- Simultaneous events: rst dominates ce and in_valid. With ce=1, every cycle accepts a new operation while retiring the oldest one.
- No backpressure: the downstream stage must consume out_valid every enabled cycle or drop ce.

Test Plan:
- N=8, SEGS=2, ce=1: A=5, B=3, op=0, sat=0 -> two enabled cycles later out_valid=1, Result=8, CarryOut=0, Overflow=0.
- Carry across segment boundary: A=0xFF, B=0x01, op=0 -> Result=0x00, CarryOut=1, Overflow=0. Then A=0x0F, B=0x01 -> Result=0x10, CarryOut=0.
- Overflow and saturation:
  - A=0x7F, B=0x01, op=0, sat=0 -> Result=0x80, Overflow=1.
  - Same operands with sat=1 -> Result=0x7F, Overflow=1, CarryOut=0.
  - A=0x80, B=0x01, op=1, sat=1 -> Result=0x80, Overflow=1, CarryOut=1.
- Subtract with borrow: A=3, B=5, op=1 -> Result=0xFE, CarryOut=0, Overflow=0.
- Streaming with stall:
  - Four back-to-back ops (1+1, 2+2, 3+3, 4+4), with ce=0 for 3 cycles after the second op.
  - Required: Results 2, 4, 6, 8 in order, outputs frozen during the stall, no duplicate out_valid pulse.
  - Repeat with SEGS=1, 4 and 8 and check latency equals SEGS in each case.
- Reset mid-flight: assert rst asynchronously with two ops in flight -> outputs and out_valid drop to 0 before the next edge. After release, no stale out_valid appears; the next op completes with normal latency.
